bin2bcd_display: RTL and testbench

//   Parametrised, sequential binary-to-BCD converter driving the LED bank.
//   On a submit pulse, captures switch input `binary`, runs a shift-add-3
//   (double-dabble) conversion one bit per clock, then registers the NDIG-digit
//   BCD result (or the raw binary, per mode) onto LEDs. Next generation of the

---
 rtl/bin2bcd_display.sv | 130 +++++++++++++
 tb/tb_bin2bcd_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_display.sv
// Sequential double-dabble binary-to-BCD converter that drives an LED bank.
// It converts one bit per clock and has a busy/done handshake, overflow saturation and dropped-submit reporting.
module bin2bcd_display #(
    parameter int IN_W  = 10,
    parameter int NDIG  = 4,
    parameter int LED_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             submit,
    input  logic             mode,
    input  logic [IN_W-1:0]  binary,
    output logic [LED_W-1:0] LEDs,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dropped
);

    localparam int BW    = 4 * NDIG;
    localparam int SW    = BW + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int CW    = (IN_W > 64) ? IN_W : 64;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [CW-1:0] MAX_VAL = CW'(pow10(NDIG) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [SW-1:0]    sr, sr_adj, sr_shift;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  bin_q;
    logic             mode_q;
    logic             submit_prev;
    logic             rise, start, ovf_now;
    logic [BW-1:0]    bcd_res;
    logic [LED_W-1:0] result;

    assign rise  = submit && !submit_prev;
    assign start = (state == S_IDLE) && rise;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_CONV;
            S_CONV:  if (cnt == CNT_W'(1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Add 3 to each nibble of 5 or more before the shift. Each nibble wraps in 4 bits and never carries into its neighbour.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < NDIG; i++) begin
            if (sr[IN_W + 4*i +: 4] >= 4'd5)
                sr_adj[IN_W + 4*i +: 4] = sr[IN_W + 4*i +: 4] + 4'd3;
        end
        sr_shift = {sr_adj[SW-2:0], 1'b0};
    end

    always_comb begin
        ovf_now = CW'(bin_q) > MAX_VAL;
        bcd_res = ovf_now ? {NDIG{4'h9}} : sr[IN_W +: BW];
        result  = mode_q ? LED_W'(bin_q) : LED_W'(bcd_res);
    end

    // NOTE: clocked state is written with non-blocking assignments only, so every register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            LEDs        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            dropped     <= 1'b0;
            sr          <= '0;
            cnt         <= '0;
            bin_q       <= '0;
            mode_q      <= 1'b0;
            submit_prev <= 1'b1;
        end else begin
            submit_prev <= submit;
            done        <= 1'b0;
            dropped     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_q  <= binary;
                        mode_q <= mode;
                        ovf    <= 1'b0;
                        sr     <= {{BW{1'b0}}, binary};
                        cnt    <= CNT_W'(IN_W);
                        busy   <= 1'b1;
                    end
                end
                S_CONV: begin
                    sr      <= sr_shift;
                    cnt     <= cnt - CNT_W'(1);
                    dropped <= rise;
                end
                S_DONE: begin
                    LEDs    <= result;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    ovf     <= ovf_now;
                    dropped <= rise;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench for bin2bcd_display: the default instance and a 14-bit instance.
// Expected LED/ovf values come from a decimal-arithmetic model.
module tb_bin2bcd_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        submit_a = 1'b0, mode_a = 1'b0;
    logic [9:0]  bin_a = '0;
    logic [15:0] leds_a;
    logic        busy_a, done_a, ovf_a, dropped_a;
    logic        submit_b = 1'b0, mode_b = 1'b0;
    logic [13:0] bin_b = '0;
    logic [15:0] leds_b;
    logic        busy_b, done_b, ovf_b, dropped_b;

    int checks = 0;
    int errors = 0;
    int drops_a = 0;

    typedef struct packed {
        logic [15:0] leds;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    bin2bcd_display dut (
        .clk(clk), .reset(reset), .submit(submit_a), .mode(mode_a), .binary(bin_a),
        .LEDs(leds_a), .busy(busy_a), .done(done_a), .ovf(ovf_a), .dropped(dropped_a)
    );

    bin2bcd_display #(.IN_W(14), .NDIG(4), .LED_W(16)) dut14 (
        .clk(clk), .reset(reset), .submit(submit_b), .mode(mode_b), .binary(bin_b),
        .LEDs(leds_b), .busy(busy_b), .done(done_b), .ovf(ovf_b), .dropped(dropped_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal model: mode 1 shows the value itself; mode 0 shows its decimal digits packed as nibbles, or 9999 when it does not fit in four digits.
    function automatic exp_t model(input int unsigned v, input bit m);
        exp_t e;
        int unsigned r, x;
        e.ovf = (v > 9999);
        if (m) begin
            e.leds = 16'(v);
        end else if (v > 9999) begin
            e.leds = 16'h9999;
        end else begin
            r = 0;
            x = v;
            for (int d = 0; d < 4; d++) begin
                r = r + ((x % 10) << (4 * d));
                x = x / 10;
            end
            e.leds = 16'(r);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (done_a) begin
                if (q_a.size() == 0) check("done_a_unexpected", 32'(done_a), 32'd0);
                else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("leds_a", 32'(leds_a), 32'(e.leds));
                    check("ovf_a", 32'(ovf_a), 32'(e.ovf));
                end
            end
            if (dropped_a) drops_a++;
            if (done_b) begin
                if (q_b.size() == 0) check("done_b_unexpected", 32'(done_b), 32'd0);
                else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("leds_b", 32'(leds_b), 32'(e.leds));
                    check("ovf_b", 32'(ovf_b), 32'(e.ovf));
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse submit for one cycle, then scramble the inputs. The task returns on the first negedge after the start edge.
    task automatic start_a(input int unsigned v, input bit m, input bit expect_done);
        @(negedge clk);
        bin_a = 10'(v);
        mode_a = m;
        submit_a = 1'b1;
        if (expect_done) q_a.push_back(model(v, m));
        @(negedge clk);
        submit_a = 1'b0;
        bin_a = 10'($urandom);
        mode_a = 1'($urandom);
    endtask

    task automatic start_b(input int unsigned v, input bit m);
        @(negedge clk);
        bin_b = 14'(v);
        mode_b = m;
        submit_b = 1'b1;
        q_b.push_back(model(v, m));
        @(negedge clk);
        submit_b = 1'b0;
        bin_b = 14'($urandom);
        mode_b = 1'($urandom);
    endtask

    initial begin
        int bc, didx, d0;

        wait_n(3);
        check("rst_leds", 32'(leds_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_dropped", 32'(dropped_a), 32'd0);
        reset = 1'b0;
        wait_n(2);

        // Latency and busy width for a single conversion.
        start_a(2, 0, 1);
        bc = 0;
        didx = -1;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (busy_a) bc++;
            if (done_a && didx < 0) didx = j;
        end
        check("busy_cycles", 32'(bc), 32'd11);
        check("done_index", 32'(didx), 32'd11);
        check("ovf_small", 32'(ovf_a), 32'd0);

        start_a(1023, 0, 1);
        wait_n(14);
        start_a(1023, 1, 1);
        wait_n(14);

        // A submit during CONV is dropped, and so is a submit in the DONE cycle.
        start_a(300, 0, 1);
        wait_n(4);
        submit_a = 1'b1;
        wait_n(1);
        check("drop_conv", 32'(dropped_a), 32'd1);
        check("busy_kept", 32'(busy_a), 32'd1);
        submit_a = 1'b0;
        wait_n(1);
        check("drop_pulse_end", 32'(dropped_a), 32'd0);
        wait_n(4);
        submit_a = 1'b1;
        wait_n(1);
        check("done_cycle", 32'(done_a), 32'd1);
        check("drop_done", 32'(dropped_a), 32'd1);
        submit_a = 1'b0;
        wait_n(3);
        check("idle_after_drop", 32'(busy_a), 32'd0);
        start_a(45, 1, 1);
        wait_n(14);

        // Reset during a conversion, with submit held high through the reset.
        start_a(999, 0, 0);
        wait_n(3);
        reset = 1'b1;
        submit_a = 1'b1;
        wait_n(1);
        reset = 1'b0;
        check("abort_leds", 32'(leds_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        bc = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (busy_a) bc++;
        end
        check("held_no_start", 32'(bc), 32'd0);
        submit_a = 1'b0;
        wait_n(1);
        start_a(999, 0, 1);
        wait_n(14);

        d0 = drops_a;
        for (int i = 0; i < 15; i++) begin
            start_a(i, 0, 1);
            wait_n(39);
        end
        check("no_drops_spaced", 32'(drops_a - d0), 32'd0);

        repeat (25) begin
            start_a($urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1);
            wait_n($urandom_range(12, 20));
        end

        // Overflow and saturation on the 14-bit instance.
        start_b(16383, 0);
        wait_n(20);
        check("ovf_sticky", 32'(ovf_b), 32'd1);
        start_b(9999, 0);
        wait_n(20);
        check("ovf_cleared", 32'(ovf_b), 32'd0);
        start_b(10000, 0);
        wait_n(20);
        start_b(16383, 1);
        wait_n(20);
        start_b(0, 0);
        wait_n(20);

        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
